// File: rtl/pps_monitor.sv
// rtl/pps_monitor.sv - PPS input qualifier, period meter and lock tracker
// Synchronizes and filters 1PPS, measures edge-to-edge period, tracks lock and loss of signal.
module pps_monitor #(
   parameter int unsigned CLK_FREQ   = 200_000_000,
   parameter int unsigned TOL        = 2_000,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned FILTER     = 4
) (
   input  logic        clk_in,
   input  logic        areset_n,
   input  logic        pps_in,
   input  logic        clear_stats,
   output logic        pps_pulse,
   output logic [31:0] pps_period,
   output logic        pps_period_upd,
   output logic        pps_period_err,
   output logic        pps_valid,
   output logic        pps_missing,
   output logic [31:0] pps_edges
);

   localparam logic [31:0] HI_LIM = 32'(CLK_FREQ + TOL);
   localparam logic [31:0] LO_LIM = 32'(CLK_FREQ - TOL);
   localparam logic [31:0] FILT_N = 32'(FILTER);
   localparam logic [31:0] LOCK_N = 32'(LOCK_COUNT);

   typedef enum logic [1:0] {NO_SIGNAL, ACQUIRE, LOCKED} state_t;

   logic        sync1_q, sync1_d, sync2_q, sync2_d;
   logic        armed_q, armed_d;
   logic [31:0] run_q, run_d;
   logic [31:0] period_cnt_q, period_cnt_d;
   logic [31:0] good_q, good_d;
   state_t      state_q, state_d;
   logic        pulse_q, pulse_d;
   logic [31:0] period_q, period_d;
   logic        upd_q, upd_d, err_q, err_d, valid_q, valid_d, missing_q, missing_d;
   logic [31:0] edges_q, edges_d;

   logic        qual_edge;
   logic [31:0] cnt_inc;
   logic        period_good;
   logic        timeout;

   assign cnt_inc     = (period_cnt_q == 32'hFFFF_FFFF) ? period_cnt_q : period_cnt_q + 32'd1;
   assign period_good = (cnt_inc >= LO_LIM) && (cnt_inc <= HI_LIM);
   assign timeout     = (period_cnt_q == HI_LIM);

   // Edge filter: re-arms only once the synchronized input has been seen low.
   always_comb begin
      sync1_d   = pps_in;
      sync2_d   = sync1_q;
      armed_d   = armed_q;
      run_d     = run_q;
      qual_edge = 1'b0;
      if (!sync2_q) begin
         armed_d = 1'b1;
         run_d   = 32'd0;
      end else if (armed_q) begin
         if (run_q + 32'd1 == FILT_N) begin
            qual_edge = 1'b1;
            armed_d   = 1'b0;
            run_d     = 32'd0;
         end else begin
            run_d = run_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      good_d       = good_q;
      period_d     = period_q;
      upd_d        = 1'b0;
      err_d        = 1'b0;
      missing_d    = missing_q;
      edges_d      = edges_q;
      pulse_d      = qual_edge;
      period_cnt_d = qual_edge ? 32'd0 : cnt_inc;
      if (clear_stats) begin
         edges_d   = 32'd0;
         missing_d = 1'b0;
      end
      if (qual_edge) begin
         edges_d   = edges_d + 32'd1;
         missing_d = 1'b0;
      end
      case (state_q)
         NO_SIGNAL: begin
            if (qual_edge) begin
               state_d = ACQUIRE;
               good_d  = 32'd0;
            end
         end
         ACQUIRE, LOCKED: begin
            if (qual_edge) begin
               period_d = cnt_inc;
               upd_d    = 1'b1;
               if (period_good) begin
                  if (state_q == ACQUIRE) begin
                     good_d = good_q + 32'd1;
                     if (good_q + 32'd1 >= LOCK_N) state_d = LOCKED;
                  end
               end else begin
                  err_d   = 1'b1;
                  good_d  = 32'd0;
                  state_d = ACQUIRE;
               end
            end else if (timeout) begin
               state_d   = NO_SIGNAL;
               missing_d = 1'b1;
            end
         end
         default: state_d = NO_SIGNAL;
      endcase
      valid_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk_in or negedge areset_n) begin
      if (!areset_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         armed_q      <= 1'b0;
         run_q        <= 32'd0;
         period_cnt_q <= 32'd0;
         good_q       <= 32'd0;
         state_q      <= NO_SIGNAL;
         pulse_q      <= 1'b0;
         period_q     <= 32'd0;
         upd_q        <= 1'b0;
         err_q        <= 1'b0;
         valid_q      <= 1'b0;
         missing_q    <= 1'b0;
         edges_q      <= 32'd0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         armed_q      <= armed_d;
         run_q        <= run_d;
         period_cnt_q <= period_cnt_d;
         good_q       <= good_d;
         state_q      <= state_d;
         pulse_q      <= pulse_d;
         period_q     <= period_d;
         upd_q        <= upd_d;
         err_q        <= err_d;
         valid_q      <= valid_d;
         missing_q    <= missing_d;
         edges_q      <= edges_d;
      end
   end

   assign pps_pulse      = pulse_q;
   assign pps_period     = period_q;
   assign pps_period_upd = upd_q;
   assign pps_period_err = err_q;
   assign pps_valid      = valid_q;
   assign pps_missing    = missing_q;
   assign pps_edges      = edges_q;

endmodule

// File: tb/tb_pps_monitor.sv
// tb/tb_pps_monitor.sv - directed self-checking bench for pps_monitor
// Small-scale parameters: 1000-cycle nominal period, +/-10 tolerance, lock after 3, filter 4.
`timescale 1ns/1ps
module tb_pps_monitor;

   logic        clk_in = 1'b0;
   logic        areset_n = 1'b0;
   logic        pps_in = 1'b0;
   logic        clear_stats = 1'b0;
   logic        pps_pulse;
   logic [31:0] pps_period;
   logic        pps_period_upd;
   logic        pps_period_err;
   logic        pps_valid;
   logic        pps_missing;
   logic [31:0] pps_edges;

   int checks = 0;
   int errors = 0;

   pps_monitor #(.CLK_FREQ(1000), .TOL(10), .LOCK_COUNT(3), .FILTER(4)) dut (
      .clk_in(clk_in), .areset_n(areset_n), .pps_in(pps_in), .clear_stats(clear_stats),
      .pps_pulse(pps_pulse), .pps_period(pps_period), .pps_period_upd(pps_period_upd),
      .pps_period_err(pps_period_err), .pps_valid(pps_valid), .pps_missing(pps_missing),
      .pps_edges(pps_edges)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // One PPS period: rise now, high for hi cycles, next rise after per cycles.
   task automatic send_period(input int per, input int hi, input int clr_at,
                              output int pulse_at, output int pulses,
                              output logic upd_seen, output logic err_seen);
      pulse_at = -1; pulses = 0; upd_seen = 1'b0; err_seen = 1'b0;
      for (int i = 0; i < per; i++) begin
         pps_in      = (i < hi);
         clear_stats = (i == clr_at);
         step();
         if (pps_pulse) begin
            pulses++;
            if (pulse_at < 0) pulse_at = i + 1;
         end
         if (pps_period_upd) upd_seen = 1'b1;
         if (pps_period_err) err_seen = 1'b1;
      end
      clear_stats = 1'b0;
   endtask

   task automatic test_reset();
      areset_n = 1'b0;
      repeat (3) step();
      checks++;
      if ({pps_pulse, pps_period_upd, pps_period_err, pps_valid, pps_missing} !== 5'b0 ||
          pps_period !== 32'd0 || pps_edges !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: flags=%b period=%0d edges=%0d, required all 0",
                  {pps_pulse, pps_period_upd, pps_period_err, pps_valid, pps_missing},
                  pps_period, pps_edges);
      end
      areset_n = 1'b1;
      repeat (5) step();
   endtask

   task automatic test_lock();
      int pa, np;
      logic u, e;
      for (int w = 1; w <= 4; w++) begin
         send_period(1000, 100, -1, pa, np, u, e);
         checks++;
         if (pa !== 6 || np !== 1) begin
            errors++;
            $display("FAIL lock_pulse_latency w%0d: at=%0d count=%0d, required at=6 count=1", w, pa, np);
         end
         checks++;
         if (u !== (w > 1) || e !== 1'b0) begin
            errors++;
            $display("FAIL lock_upd_err w%0d: upd=%b err=%b, required upd=%b err=0", w, u, e, w > 1);
         end
         checks++;
         if (pps_valid !== (w == 4)) begin
            errors++;
            $display("FAIL lock_valid w%0d: %b, required %b", w, pps_valid, w == 4);
         end
      end
      checks++;
      if (pps_period !== 32'd1000 || pps_edges !== 32'd4) begin
         errors++;
         $display("FAIL lock_period_edges: period=%0d edges=%0d, required 1000/4", pps_period, pps_edges);
      end
   endtask

   task automatic test_bad_period();
      int pa, np;
      logic u, e;
      send_period(1011, 100, -1, pa, np, u, e);
      send_period(1000, 100, -1, pa, np, u, e);
      checks++;
      if (e !== 1'b1 || u !== 1'b1 || pps_period !== 32'd1011 || pps_valid !== 1'b0 || pps_missing !== 1'b0) begin
         errors++;
         $display("FAIL bad_1011: err=%b upd=%b period=%0d valid=%b missing=%b, required 1/1/1011/0/0",
                  e, u, pps_period, pps_valid, pps_missing);
      end
      for (int w = 1; w <= 3; w++) begin
         send_period(1000, 100, -1, pa, np, u, e);
         checks++;
         if (pps_valid !== (w == 3) || e !== 1'b0) begin
            errors++;
            $display("FAIL relock_after_err w%0d: valid=%b err=%b, required valid=%b err=0", w, pps_valid, e, w == 3);
         end
      end
   endtask

   task automatic test_timeout();
      int pa, np;
      logic u, e;
      for (int i = 0; i < 1017; i++) begin
         pps_in = (i < 100);
         step();
         if (i + 1 == 1016) begin
            checks++;
            if (pps_missing !== 1'b0 || pps_valid !== 1'b1) begin
               errors++;
               $display("FAIL pre_timeout: missing=%b valid=%b, required 0/1", pps_missing, pps_valid);
            end
         end
      end
      checks++;
      if (pps_missing !== 1'b1 || pps_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout: missing=%b valid=%b, required 1/0", pps_missing, pps_valid);
      end
      repeat (400) step();
      send_period(1000, 100, -1, pa, np, u, e);
      checks++;
      if (u !== 1'b0 || np !== 1 || pps_missing !== 1'b0) begin
         errors++;
         $display("FAIL edge_after_timeout: upd=%b pulses=%0d missing=%b, required 0/1/0", u, np, pps_missing);
      end
      for (int w = 1; w <= 3; w++) begin
         send_period(1000, 100, -1, pa, np, u, e);
         checks++;
         if (pps_valid !== (w == 3)) begin
            errors++;
            $display("FAIL relock_after_timeout w%0d: valid=%b, required %b", w, pps_valid, w == 3);
         end
      end
   endtask

   task automatic test_glitch();
      int pa, np;
      logic u, e;
      logic [31:0] edges0;
      edges0 = pps_edges;
      for (int g = 1; g <= 3; g++) begin
         send_period(21, g, -1, pa, np, u, e);
         checks++;
         if (np !== 0 || pps_edges !== edges0) begin
            errors++;
            $display("FAIL glitch_%0d: pulses=%0d edges=%0d, required 0/%0d", g, np, pps_edges, edges0);
         end
      end
      checks++;
      if (pps_missing !== 1'b1) begin
         errors++;
         $display("FAIL glitch_timeout_missing: %b, required 1", pps_missing);
      end
      send_period(1000, 4, -1, pa, np, u, e);
      checks++;
      if (np !== 1 || pa !== 6 || pps_edges !== edges0 + 32'd1 || pps_missing !== 1'b0) begin
         errors++;
         $display("FAIL width4_edge: pulses=%0d at=%0d edges=%0d missing=%b, required 1/6/%0d/0",
                  np, pa, pps_edges, pps_missing, edges0 + 32'd1);
      end
   endtask

   task automatic test_tolerance();
      int pa, np;
      logic u, e;
      send_period(990, 100, -1, pa, np, u, e);
      send_period(1010, 100, -1, pa, np, u, e);
      checks++;
      if (e !== 1'b0 || u !== 1'b1 || pps_period !== 32'd990) begin
         errors++;
         $display("FAIL tol_990: err=%b upd=%b period=%0d, required 0/1/990", e, u, pps_period);
      end
      send_period(989, 100, -1, pa, np, u, e);
      checks++;
      if (e !== 1'b0 || pps_period !== 32'd1010 || pps_valid !== 1'b1) begin
         errors++;
         $display("FAIL tol_1010: err=%b period=%0d valid=%b, required 0/1010/1", e, pps_period, pps_valid);
      end
      send_period(1000, 100, -1, pa, np, u, e);
      checks++;
      if (e !== 1'b1 || pps_period !== 32'd989 || pps_valid !== 1'b0) begin
         errors++;
         $display("FAIL tol_989: err=%b period=%0d valid=%b, required 1/989/0", e, pps_period, pps_valid);
      end
   endtask

   task automatic test_reset_clear();
      int pa, np;
      logic u, e;
      repeat (3) send_period(1000, 100, -1, pa, np, u, e);
      checks++;
      if (pps_valid !== 1'b1) begin
         errors++;
         $display("FAIL prereset_locked: valid=%b, required 1", pps_valid);
      end
      areset_n = 1'b0;
      #1;
      checks++;
      if ({pps_pulse, pps_period_upd, pps_period_err, pps_valid, pps_missing} !== 5'b0 ||
          pps_period !== 32'd0 || pps_edges !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: flags=%b period=%0d edges=%0d, required all 0",
                  {pps_pulse, pps_period_upd, pps_period_err, pps_valid, pps_missing},
                  pps_period, pps_edges);
      end
      step();
      areset_n = 1'b1;
      repeat (3) step();
      send_period(1000, 100, -1, pa, np, u, e);
      checks++;
      if (u !== 1'b0 || pps_edges !== 32'd1) begin
         errors++;
         $display("FAIL first_edge_after_reset: upd=%b edges=%0d, required 0/1", u, pps_edges);
      end
      send_period(1000, 100, -1, pa, np, u, e);
      send_period(1000, 100, 5, pa, np, u, e);
      checks++;
      if (pps_edges !== 32'd1 || np !== 1) begin
         errors++;
         $display("FAIL clear_on_edge: edges=%0d pulses=%0d, required 1/1", pps_edges, np);
      end
      clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
      step();
      checks++;
      if (pps_edges !== 32'd0) begin
         errors++;
         $display("FAIL clear_no_edge: edges=%0d, required 0", pps_edges);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_bad_period();
      test_timeout();
      test_glitch();
      test_tolerance();
      test_reset_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
